pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage of the RISC-V pipeline. Produces the instruction fetch address and chip-enable, and advances by a fixed increment only when the instruction memory acknowledges and IF is not stalled. Accepts control-flow redirects from ID (jumps) and EX (branches/JALR). A one-entry pending-redirect buffer holds a redirect that arrives while IF is stalled until the stall releases.

---
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address generator handshake bundle (stall, ack, redirects in; pc, ce, status out).
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall_i;
  logic               if_ack_i;
  logic               ex_redir_i;
  logic [ADDR_W-1:0]  ex_target_i;
  logic               id_redir_i;
  logic [ADDR_W-1:0]  id_target_i;
  logic [ADDR_W-1:0]  pc_o;
  logic               ce_o;
  logic               redir_taken_o;
  logic               pend_valid_o;
  logic               misalign_o;
  modport master (
    output stall_i, if_ack_i, ex_redir_i, ex_target_i, id_redir_i, id_target_i,
    input  pc_o, ce_o, redir_taken_o, pend_valid_o, misalign_o
  );
  modport slave (
    input  stall_i, if_ack_i, ex_redir_i, ex_target_i, id_redir_i, id_target_i,
    output pc_o, ce_o, redir_taken_o, pend_valid_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with EX/ID redirects and a one-entry redirect buffer held across IF stalls.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets load TRAP_VEC and pulse misalign_o.
module pc_gen #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              STALL_W   = 6,
  parameter int              INC       = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 'h100
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.slave   bus
);
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_ex_q, pend_ex_d;
  logic              redir_q, redir_d;
  logic              mis_q, mis_d;
  logic              stall_if, adv, load, mis;
  logic [ADDR_W-1:0] tgt, ld_pc;
  logic              unused_ok;
  assign stall_if = bus.stall_i[0];
  assign adv      = bus.if_ack_i & ~stall_if;
  // EX beats a buffered redirect, which beats a fresh ID redirect
  assign tgt  = bus.ex_redir_i ? bus.ex_target_i : pend_q ? pend_tgt_q : bus.id_target_i;
  assign load = bus.ex_redir_i | pend_q | bus.id_redir_i;
`ifdef PC_MISALIGN_TRAP_EN
  assign mis   = |tgt[1:0];
  assign ld_pc = mis ? TRAP_VEC : tgt;
`else
  assign mis   = 1'b0;
  assign ld_pc = {tgt[ADDR_W-1:2], 2'b00};
`endif
  assign unused_ok = ^{bus.stall_i[STALL_W-1:1], tgt[1:0]};
  always_comb begin
    ce_d       = 1'b1;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pend_ex_d  = pend_ex_q;
    redir_d    = 1'b0;
    mis_d      = 1'b0;
    if (!ce_q) begin
      pc_d = RESET_VEC;
    end else if (stall_if) begin
      if (bus.ex_redir_i) begin
        pend_d     = 1'b1;
        pend_tgt_d = bus.ex_target_i;
        pend_ex_d  = 1'b1;
      end else if (bus.id_redir_i && !(pend_q && pend_ex_q)) begin
        pend_d     = 1'b1;
        pend_tgt_d = bus.id_target_i;
        pend_ex_d  = 1'b0;
      end
    end else if (load) begin
      pc_d    = ld_pc;
      redir_d = 1'b1;
      mis_d   = mis;
      pend_d  = 1'b0;
    end else if (adv) begin
      pc_d = pc_q + ADDR_W'(INC);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q       <= 1'b0;
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      pend_ex_q  <= 1'b0;
      redir_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      ce_q       <= ce_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pend_ex_q  <= pend_ex_d;
      redir_q    <= redir_d;
      mis_q      <= mis_d;
    end
  end
  assign bus.pc_o          = pc_q;
  assign bus.ce_o          = ce_q;
  assign bus.redir_taken_o = redir_q;
  assign bus.pend_valid_o  = pend_q;
  assign bus.misalign_o    = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plan checks plus randomized traffic against a queue-based reference model.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  typedef struct { logic [31:0] t; bit ex; } pend_t;
  pend_t       pq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_ce = 0, m_rt = 0, m_mis = 0;
  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();
  pc_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] land(input logic [31:0] t, output bit m);
`ifdef PC_MISALIGN_TRAP_EN
    m = (t[1:0] != 2'b00);
    return m ? 32'h100 : t;
`else
    m = 0;
    return t & ~32'h3;
`endif
  endfunction
  task automatic model_step();
    logic [31:0] t;
    bit          m;
    if (rst) begin
      m_ce = 0; m_pc = 32'h0; m_rt = 0; m_mis = 0; pq.delete();
    end else if (!m_ce) begin
      m_ce = 1; m_pc = 32'h0; m_rt = 0; m_mis = 0;
    end else if (bus.stall_i[0]) begin
      m_rt = 0; m_mis = 0;
      if (bus.ex_redir_i) begin
        pq.delete(); pq.push_back('{bus.ex_target_i, 1'b1});
      end else if (bus.id_redir_i && (pq.size() == 0 || !pq[0].ex)) begin
        pq.delete(); pq.push_back('{bus.id_target_i, 1'b0});
      end
    end else if (bus.ex_redir_i || pq.size() != 0 || bus.id_redir_i) begin
      t = bus.ex_redir_i ? bus.ex_target_i : (pq.size() != 0) ? pq[0].t : bus.id_target_i;
      m_pc = land(t, m);
      m_mis = m; m_rt = 1; pq.delete();
    end else begin
      m_rt = 0; m_mis = 0;
      if (bus.if_ack_i) m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic cyc(input bit r, input logic [5:0] st, input bit ack,
                     input bit ex, input logic [31:0] ext, input bit id, input logic [31:0] idt);
    rst = r;
    bus.stall_i = st; bus.if_ack_i = ack;
    bus.ex_redir_i = ex; bus.ex_target_i = ext;
    bus.id_redir_i = id; bus.id_target_i = idt;
    @(posedge clk);
    model_step();
    #1;
    check("pc", bus.pc_o, m_pc);
    check("ce", 32'(bus.ce_o), 32'(m_ce));
    check("redir_taken", 32'(bus.redir_taken_o), 32'(m_rt));
    check("pend_valid", 32'(bus.pend_valid_o), 32'(pq.size() != 0));
    check("misalign", 32'(bus.misalign_o), 32'(m_mis));
  endtask
  initial begin
    logic [31:0] a, b;
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 32'h40, 1, 32'h80);
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_ce", 32'(bus.ce_o), 32'h0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("first_pc", bus.pc_o, 32'h0);
    check("first_ce", 32'(bus.ce_o), 32'h1);
    cyc(0, 0, 1, 0, 0, 0, 0); check("seq4", bus.pc_o, 32'h4);
    cyc(0, 0, 1, 0, 0, 0, 0); check("seq8", bus.pc_o, 32'h8);
    cyc(0, 0, 1, 0, 0, 0, 0); check("seqC", bus.pc_o, 32'hC);
    cyc(0, 0, 1, 0, 0, 0, 0); check("ack1", bus.pc_o, 32'h10);
    cyc(0, 0, 0, 0, 0, 0, 0); check("ack0_hold", bus.pc_o, 32'h10);
    cyc(0, 0, 1, 0, 0, 0, 0); check("ack1_again", bus.pc_o, 32'h14);
    cyc(0, 1, 1, 0, 0, 1, 32'h40);
    cyc(0, 1, 1, 1, 32'h80, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    check("stall_hold", bus.pc_o, 32'h14);
    check("stall_pend", 32'(bus.pend_valid_o), 32'h1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("release_pc", bus.pc_o, 32'h80);
    check("release_rt", 32'(bus.redir_taken_o), 32'h1);
    check("release_pv", 32'(bus.pend_valid_o), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rt_pulse", 32'(bus.redir_taken_o), 32'h0);
    cyc(0, 1, 1, 1, 32'h90, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, 32'h50);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("ex_not_overwritten", bus.pc_o, 32'h90);
    cyc(0, 0, 1, 1, 32'h200, 1, 32'h300);
    check("ex_over_id", bus.pc_o, 32'h200);
    check("ex_over_id_rt", 32'(bus.redir_taken_o), 32'h1);
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("wrap", bus.pc_o, 32'h0);
    cyc(0, 0, 1, 1, 32'h102, 0, 0);
    check("misalign_pc", bus.pc_o, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_flag", 32'(bus.misalign_o), 32'h1);
`else
    check("misalign_flag", 32'(bus.misalign_o), 32'h0);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("misalign_pulse", 32'(bus.misalign_o), 32'h0);
    cyc(0, 1, 1, 0, 0, 1, 32'h60);
    cyc(1, 1, 1, 0, 0, 0, 0);
    check("midstall_rst_pv", 32'(bus.pend_valid_o), 32'h0);
    check("midstall_rst_pc", bus.pc_o, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(3) != 0) b[1:0] = 2'b00;
      cyc($urandom_range(63) == 0, {5'($urandom), $urandom_range(9) < 3}, $urandom_range(3) != 0,
          $urandom_range(99) < 15, a, $urandom_range(99) < 20, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
